// File: rtl/mod_cache_dma_if.sv
// Control and cache-port bundle for the cache block-copy/fill DMA engine.
interface mod_cache_dma_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          start;
    logic          mode;
    logic [AW-1:0] srcAddr;
    logic [AW-1:0] dstAddr;
    logic [15:0]   len;
    logic [DW-1:0] fillData;
    logic          busy;
    logic          done;
    logic [15:0]   count;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWData;
    logic          memWE;
    logic [DW-1:0] memRData;

    modport master (
        input  start, mode, srcAddr, dstAddr, len, fillData, memRData,
        output busy, done, count, memAddr, memWData, memWE
    );

    modport slave (
        output start, mode, srcAddr, dstAddr, len, fillData, memRData,
        input  busy, done, count, memAddr, memWData, memWE
    );
endinterface

// File: rtl/mod_cache_dma.sv
// Cache DMA engine: block copy (read/write alternating) or block fill
// (consecutive writes) over the cache RAM port, one-cycle done pulse.
module mod_cache_dma #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input logic             clk,
    input logic             rst,
    mod_cache_dma_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [15:0]           len_q, len_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           cnt_inc;

    assign cnt_inc   = cnt_q + 16'd1;
    assign bus.count = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        fill_d       = fill_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.memWE    = 1'b0;
        bus.memAddr  = '0;
        bus.memWData = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d = bus.mode;
                    src_d  = bus.srcAddr;
                    dst_d  = bus.dstAddr;
                    len_d  = bus.len;
                    fill_d = bus.fillData;
                    cnt_d  = '0;
                    if (bus.len == 16'd0) state_d = S_DONE;
                    else if (bus.mode)    state_d = S_WRITE;
                    else                  state_d = S_READ;
                end
            end
            S_READ: begin
                bus.busy    = 1'b1;
                bus.memAddr = src_q + ADDR_WIDTH'(cnt_q);
                data_d      = bus.memRData;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                bus.busy     = 1'b1;
                bus.memWE    = 1'b1;
                bus.memAddr  = dst_q + ADDR_WIDTH'(cnt_q);
                bus.memWData = mode_q ? fill_q : data_q;
                cnt_d        = cnt_inc;
                // cnt_q doubles as the word index i
                if (cnt_inc == len_q) state_d = S_DONE;
                else if (mode_q)      state_d = S_WRITE;
                else                  state_d = S_READ;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mod_cache_dma.sv
// Bench for mod_cache_dma: cache model, expected-write scoreboard,
// directed copy/fill/zero/wrap/overlap/reset scenarios.
module tb_mod_cache_dma;
    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mod_cache_dma_if #(.DW(16), .AW(16)) bus ();

    mod_cache_dma #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:4095];
    logic        pl_we = 1'b0;
    logic [15:0] pl_a  = 16'h0;
    logic [15:0] pl_d  = 16'h0;

    // cache maps 0x0000..0x0FFF only
    always @(posedge clk) begin
        if (pl_we)
            mem[pl_a[11:0]] <= pl_d;
        else if (bus.memWE && bus.memAddr < 16'h1000)
            mem[bus.memAddr[11:0]] <= bus.memWData;
    end

    assign bus.memRData = (bus.memAddr < 16'h1000) ?
                          mem[bus.memAddr[11:0]] : 16'h0;

    int  total = 0;
    int  bad   = 0;
    wr_t exp_q[$];

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pre(input logic [15:0] a, input logic [15:0] d);
        pl_a  = a;
        pl_d  = d;
        pl_we = 1'b1;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        wr_t e;
        @(negedge clk);
        if (bus.memWE === 1'b1) begin
            chk("write_expected", 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", bus.memAddr, e.a);
                chk("wr_data", bus.memWData, e.d);
            end
        end
    endtask

    task automatic run(input logic m, input logic [15:0] s,
                       input logic [15:0] d, input logic [15:0] n,
                       input logic [15:0] f, input int poke,
                       output int busy_n, output int done_at);
        bus.mode     = m;
        bus.srcAddr  = s;
        bus.dstAddr  = d;
        bus.len      = n;
        bus.fillData = f;
        bus.start    = 1'b1;
        busy_n       = 0;
        done_at      = -1;
        for (int c = 1; c <= 200; c++) begin
            cyc();
            bus.start = (c == poke);
            if (c == 1) begin
                bus.mode     = 1'($urandom);
                bus.srcAddr  = 16'($urandom);
                bus.dstAddr  = 16'($urandom);
                bus.len      = 16'($urandom);
                bus.fillData = 16'($urandom);
            end
            if (bus.busy === 1'b1) busy_n++;
            if (bus.done === 1'b1) begin
                done_at = c;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic idle_check(input logic [15:0] n);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("idle_busy", 16'(bus.busy), 16'd0);
            chk("idle_done", 16'(bus.done), 16'd0);
            chk("hold_count", bus.count, n);
        end
        chk("queue_empty", 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        int b, dn;
        bus.start    = 1'b0;
        bus.mode     = 1'b0;
        bus.srcAddr  = 16'h0;
        bus.dstAddr  = 16'h0;
        bus.len      = 16'h0;
        bus.fillData = 16'h0;

        #3 rst = 1'b0;
        #1;
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_done", 16'(bus.done), 16'd0);
        chk("rst_we", 16'(bus.memWE), 16'd0);
        chk("rst_count", bus.count, 16'd0);
        chk("rst_addr", bus.memAddr, 16'd0);
        chk("rst_wdata", bus.memWData, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            pre(16'h0100 + 16'(i), 16'hA000 + 16'(i));
            pre(16'h0200 + 16'(i), 16'h0);
            pre(16'h0300 + 16'(i), 16'hDEAD);
        end
        pre(16'h0000, 16'h0);
        pre(16'h0040, 16'h1111);
        for (int i = 1; i < 4; i++) pre(16'h0040 + 16'(i), 16'h0);
        cyc();

        // copy 4 words, stray start mid-transfer
        for (int i = 0; i < 4; i++)
            push(16'h0200 + 16'(i), 16'hA000 + 16'(i));
        run(1'b0, 16'h0100, 16'h0200, 16'd4, 16'h0, 3, b, dn);
        chk("copy_busy", 16'(b), 16'd8);
        chk("copy_done", 16'(dn), 16'd9);
        chk("copy_count", bus.count, 16'd4);
        idle_check(16'd4);
        for (int i = 0; i < 4; i++)
            chk("copy_mem", mem[12'h200 + 12'(i)], 16'hA000 + 16'(i));

        // fill 3 words
        for (int i = 0; i < 3; i++) push(16'h0010 + 16'(i), 16'h5A5A);
        run(1'b1, 16'h0, 16'h0010, 16'd3, 16'h5A5A, 0, b, dn);
        chk("fill_busy", 16'(b), 16'd3);
        chk("fill_done", 16'(dn), 16'd4);
        chk("fill_count", bus.count, 16'd3);
        idle_check(16'd3);
        for (int i = 0; i < 3; i++)
            chk("fill_mem", mem[12'h010 + 12'(i)], 16'h5A5A);

        // zero length
        run(1'b0, 16'h0100, 16'h0200, 16'd0, 16'h0, 0, b, dn);
        chk("zero_busy", 16'(b), 16'd0);
        chk("zero_done", 16'(dn), 16'd1);
        chk("zero_count", bus.count, 16'd0);
        idle_check(16'd0);

        // address wrap past 0xFFFF
        push(16'hFFFE, 16'h3C3C);
        push(16'hFFFF, 16'h3C3C);
        push(16'h0000, 16'h3C3C);
        run(1'b1, 16'h0, 16'hFFFE, 16'd3, 16'h3C3C, 0, b, dn);
        chk("wrap_done", 16'(dn), 16'd4);
        idle_check(16'd3);
        chk("wrap_mem0", mem[0], 16'h3C3C);

        // overlapping forward copy, start pulsed during DONE
        for (int i = 1; i < 4; i++) push(16'h0040 + 16'(i), 16'h1111);
        run(1'b0, 16'h0040, 16'h0041, 16'd3, 16'h0, 6, b, dn);
        chk("ovl_busy", 16'(b), 16'd6);
        chk("ovl_done", 16'(dn), 16'd7);
        idle_check(16'd3);
        for (int i = 1; i < 4; i++)
            chk("ovl_mem", mem[12'h040 + 12'(i)], 16'h1111);

        // reset during the second WRITE of a 4-word copy
        push(16'h0300, 16'hA000);
        bus.mode    = 1'b0;
        bus.srcAddr = 16'h0100;
        bus.dstAddr = 16'h0300;
        bus.len     = 16'd4;
        bus.start   = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
        cyc();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_busy", 16'(bus.busy), 16'd0);
        chk("mid_done", 16'(bus.done), 16'd0);
        chk("mid_we", 16'(bus.memWE), 16'd0);
        chk("mid_count", bus.count, 16'd0);
        chk("mid_addr", bus.memAddr, 16'd0);
        chk("mid_wdata", bus.memWData, 16'd0);
        cyc();
        cyc();
        rst = 1'b1;
        idle_check(16'd0);
        chk("mid_mem0", mem[12'h300], 16'hA000);
        chk("mid_mem1", mem[12'h301], 16'hDEAD);

        for (int i = 0; i < 4; i++)
            push(16'h0300 + 16'(i), 16'hA000 + 16'(i));
        run(1'b0, 16'h0100, 16'h0300, 16'd4, 16'h0, 0, b, dn);
        chk("again_done", 16'(dn), 16'd9);
        idle_check(16'd4);
        chk("again_mem3", mem[12'h303], 16'hA003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
